// File: rtl/bt656_pkg.sv
// BT.656 encoder shared definitions: XY code layout, fixed stream bytes,
// and 625/525 timing sets.
package bt656_pkg;

    // Bit positions inside the XY timing-code byte
    localparam int XY_ONE = 7;
    localparam int XY_F   = 6;
    localparam int XY_V   = 5;
    localparam int XY_H   = 4;
    localparam int XY_P3  = 3;
    localparam int XY_P2  = 2;
    localparam int XY_P1  = 1;
    localparam int XY_P0  = 0;

    // Blanking and preamble bytes
    localparam logic [7:0] BLANK_C = 8'h80;
    localparam logic [7:0] BLANK_Y = 8'h10;
    localparam logic [7:0] PRE_FF  = 8'hFF;
    localparam logic [7:0] PRE_00  = 8'h00;

    // 625-line timing
    localparam int H_ACTIVE_625   = 720;
    localparam int H_BLANK_625    = 280;
    localparam int V_TOTAL_625    = 625;
    localparam int F1_LINE_625    = 313;
    localparam int ACT1_FIRST_625 = 23;
    localparam int ACT1_LAST_625  = 310;
    localparam int ACT2_FIRST_625 = 336;
    localparam int ACT2_LAST_625  = 623;

    // 525-line timing
    localparam int H_ACTIVE_525   = 720;
    localparam int H_BLANK_525    = 268;
    localparam int V_TOTAL_525    = 525;
    localparam int F1_LINE_525    = 266;
    localparam int ACT1_FIRST_525 = 20;
    localparam int ACT1_LAST_525  = 263;
    localparam int ACT2_FIRST_525 = 283;
    localparam int ACT2_LAST_525  = 525;

    // Where the current byte falls inside the line
    typedef enum logic [1:0] {
        REG_EAV,
        REG_BLANK,
        REG_SAV,
        REG_ACT
    } region_e;

    // Timing flags of the current line/byte
    typedef struct packed {
        logic f;
        logic v;
        logic h;
    } fvh_t;

endpackage

// File: rtl/bt656_xy_gen.sv
// BT.656 XY timing-code generator with protection bits.
// Pure combinational; reusable by stream checkers.
module bt656_xy_gen
    import bt656_pkg::*;
(
    input  fvh_t       fvh,
    output logic [7:0] xy
);

    // Assemble {1,F,V,H,P3..P0}
    always_comb begin
        xy        = '0;
        xy[XY_ONE] = 1'b1;
        xy[XY_F]  = fvh.f;
        xy[XY_V]  = fvh.v;
        xy[XY_H]  = fvh.h;
        xy[XY_P3] = fvh.v ^ fvh.h;
        xy[XY_P2] = fvh.f ^ fvh.h;
        xy[XY_P1] = fvh.f ^ fvh.v;
        xy[XY_P0] = fvh.f ^ fvh.v ^ fvh.h;
    end

endmodule

// File: rtl/bt656_encoder.sv
// BT.656 4:2:2 byte-stream encoder, monochrome (Cb=Cr=0x80).
// Optional macro BT656_CLIP_EN clips active Y 0x00/0xFF to 0x01/0xFE.
module bt656_encoder
    import bt656_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_625,
    parameter int H_BLANK    = H_BLANK_625,
    parameter int V_TOTAL    = V_TOTAL_625,
    parameter int F1_LINE    = F1_LINE_625,
    parameter int ACT1_FIRST = ACT1_FIRST_625,
    parameter int ACT1_LAST  = ACT1_LAST_625,
    parameter int ACT2_FIRST = ACT2_FIRST_625,
    parameter int ACT2_LAST  = ACT2_LAST_625
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic [7:0] y_in,
    input  logic       y_in_valid,
    output logic       y_rd,
    output logic [7:0] d_out,
    output logic       field,
    output logic       vblank,
    output logic       hactive,
    output logic       frame_start,
    output logic       underflow
);

    localparam int H_TOTAL = 8 + H_BLANK + 2 * H_ACTIVE;

    if (H_TOTAL >= 2048) begin : g_bad_h
        $error("bt656_encoder: H_TOTAL must be < 2048");
    end
    if (V_TOTAL >= 1024) begin : g_bad_v
        $error("bt656_encoder: V_TOTAL must be < 1024");
    end

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] SAV_S  = 11'(4 + H_BLANK);
    localparam logic [10:0] ACT_S  = 11'(8 + H_BLANK);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL);
    localparam logic [9:0]  F1_L   = 10'(F1_LINE);
    localparam logic [9:0]  A1_F   = 10'(ACT1_FIRST);
    localparam logic [9:0]  A1_L   = 10'(ACT1_LAST);
    localparam logic [9:0]  A2_F   = 10'(ACT2_FIRST);
    localparam logic [9:0]  A2_L   = 10'(ACT2_LAST);

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [7:0]  d_out_q, d_out_d;
    logic        field_q, field_d;
    logic        vblank_q, vblank_d;
    logic        hactive_q, hactive_d;
    logic        frame_start_q, frame_start_d;
    logic        underflow_q, underflow_d;

    region_e     region;
    fvh_t        fvh;
    logic [7:0]  xy;
    logic [7:0]  code;
    logic [7:0]  y_byte;
    logic [1:0]  code_idx;
    logic        act_odd;
    logic        fs_line;

    // Line flags and byte region from the counters
    always_comb begin
        fvh.f = (v_cnt_q >= F1_L);
        fvh.v = !((v_cnt_q >= A1_F && v_cnt_q <= A1_L) ||
                  (v_cnt_q >= A2_F && v_cnt_q <= A2_L));
        fvh.h = (h_cnt_q < 11'd4);
        if (h_cnt_q < 11'd4) begin
            region = REG_EAV;
        end else if (h_cnt_q < SAV_S) begin
            region = REG_BLANK;
        end else if (h_cnt_q < ACT_S) begin
            region = REG_SAV;
        end else begin
            region = REG_ACT;
        end
        code_idx = (region == REG_EAV) ? h_cnt_q[1:0]
                                       : h_cnt_q[1:0] - SAV_S[1:0];
        act_odd  = h_cnt_q[0] ^ ACT_S[0];
        fs_line  = (v_cnt_q == A1_F) || (v_cnt_q == A2_F);
    end

    bt656_xy_gen u_xy (
        .fvh (fvh),
        .xy  (xy)
    );

    // Luma requested on every Y slot of an active line
    assign y_rd = !fvh.v && (region == REG_ACT) && act_odd;

`ifdef BT656_CLIP_EN
    // Keep 0x00/0xFF reserved for timing codes
    always_comb begin
        y_byte = y_in;
        if (y_in == 8'h00) y_byte = 8'h01;
        if (y_in == 8'hFF) y_byte = 8'hFE;
    end
`else
    assign y_byte = y_in;
`endif

    // Counters, byte mux and output-register inputs
    always_comb begin
        h_cnt_d = h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd1 : v_cnt_q + 10'd1;
        end

        unique case (code_idx)
            2'd0:    code = PRE_FF;
            2'd3:    code = xy;
            default: code = PRE_00;
        endcase

        d_out_d = BLANK_Y;
        unique case (region)
            REG_EAV, REG_SAV: d_out_d = code;
            REG_BLANK: d_out_d = h_cnt_q[0] ? BLANK_Y : BLANK_C;
            REG_ACT: begin
                if (!act_odd)        d_out_d = BLANK_C;
                else if (fvh.v)      d_out_d = BLANK_Y;
                else if (y_in_valid) d_out_d = y_byte;
                else                 d_out_d = BLANK_Y;
            end
        endcase

        field_d       = fvh.f;
        vblank_d      = fvh.v;
        hactive_d     = (region == REG_ACT) && !fvh.v;
        frame_start_d = (region == REG_SAV) && (code_idx == 2'd3) && fs_line;
        underflow_d   = underflow_q || (y_rd && !y_in_valid);
    end

    // State and output registers
    always_ff @(posedge pclk) begin
        if (reset) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= 10'd1;
            d_out_q       <= BLANK_Y;
            field_q       <= 1'b0;
            vblank_q      <= 1'b1;
            hactive_q     <= 1'b0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            d_out_q       <= d_out_d;
            field_q       <= field_d;
            vblank_q      <= vblank_d;
            hactive_q     <= hactive_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign d_out       = d_out_q;
    assign field       = field_q;
    assign vblank      = vblank_q;
    assign hactive     = hactive_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_bt656_encoder.sv
// Directed bench for bt656_encoder: full 625 line width, short 14-line frame.
// Honors BT656_CLIP_EN for the clip expectations.
module tb_bt656_encoder;

    localparam int HT = 1728;
    localparam int VT = 14;

    logic       pclk = 1'b0;
    logic       reset;
    logic [7:0] y_in;
    logic       y_in_valid;
    logic       y_rd;
    logic [7:0] d_out;
    logic       field, vblank, hactive, frame_start, underflow;

    int n_chk = 0;
    int n_fail = 0;
    int ln, hc;
    int yrd_cnt = 0;
    int ramp_err = 0;
    int ynext = 0;
    bit drop = 0;
    logic [7:0] drop_obs;
    logic [7:0] last_fed;
    logic [7:0] ovr_q[$];
    logic [7:0] ovr_obs[$];

    bt656_encoder #(
        .H_ACTIVE   (720),
        .H_BLANK    (280),
        .V_TOTAL    (VT),
        .F1_LINE    (8),
        .ACT1_FIRST (3),
        .ACT1_LAST  (6),
        .ACT2_FIRST (10),
        .ACT2_LAST  (13)
    ) dut (
        .pclk        (pclk),
        .reset       (reset),
        .y_in        (y_in),
        .y_in_valid  (y_in_valid),
        .y_rd        (y_rd),
        .d_out       (d_out),
        .field       (field),
        .vblank      (vblank),
        .hactive     (hactive),
        .frame_start (frame_start),
        .underflow   (underflow)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (line %0d h %0d)",
                     tag, got, exp, ln, hc);
        end
    endtask

    function automatic logic [7:0] exp_y(input logic [7:0] v);
`ifdef BT656_CLIP_EN
        if (v == 8'h00) return 8'h01;
        if (v == 8'hFF) return 8'hFE;
`endif
        return v;
    endfunction

    // One byte clock: feed luma on request, then check the fed byte
    task automatic tick();
        logic fed, drop_now, ovr_now;
        logic [7:0] e;
        fed = 0; drop_now = 0; ovr_now = 0; e = 8'h00;
        @(negedge pclk);
        y_in_valid = 1'b1;
        if (y_rd) begin
            yrd_cnt++;
            fed = 1;
            if (drop) begin
                y_in_valid = 1'b0;
                drop = 0;
                drop_now = 1;
                e = 8'h10;
            end else if (ovr_q.size() > 0) begin
                y_in = ovr_q.pop_front();
                e = exp_y(y_in);
                ovr_now = 1;
            end else begin
                y_in = 8'h20 + 8'(ynext % 128);
                ynext++;
                e = y_in;
            end
            last_fed = e;
        end
        @(posedge pclk);
        #1;
        if (fed && !reset) begin
            if (d_out !== e) ramp_err++;
            if (drop_now) drop_obs = d_out;
            if (ovr_now) ovr_obs.push_back(d_out);
        end
        hc++;
        if (hc == HT) begin
            hc = 0;
            ln = (ln == VT) ? 1 : ln + 1;
        end
    endtask

    task automatic run_to(input int l, input int h);
        int n = 0;
        while (!(ln == l && hc == h) && n < 40000) begin
            tick();
            n++;
        end
        if (n >= 40000) chk("run_to_timeout", 32'(hc), 32'(h));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk(tag, {19'd0, d_out, field, vblank, hactive, frame_start,
                  underflow}, {19'd0, 8'h10, 5'b01000});
    endtask

    initial begin
        logic [7:0] eav1 [4];
        logic [7:0] sav1 [4];
        int berr;
        eav1 = '{8'hFF, 8'h00, 8'h00, 8'hB6};
        sav1 = '{8'hFF, 8'h00, 8'h00, 8'hAB};
        reset = 1'b1;
        y_in = 8'h00;
        y_in_valid = 1'b1;
        ln = 1; hc = -1;
        tick();
        tick();
        chk_reset_vals("reset_outs");
        chk("reset_y_rd", 32'(y_rd), 0);
        ln = 1; hc = -1;
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            tick();
            chk("eav_l1", 32'(d_out), 32'(eav1[i]));
        end
        berr = 0;
        for (int i = 0; i < 280; i++) begin
            tick();
            if (d_out !== ((i % 2 == 0) ? 8'h80 : 8'h10)) berr++;
        end
        chk("blank_l1", 32'(berr), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("sav_l1", 32'(d_out), 32'(sav1[i]));
        end
        chk("vblank_l1", 32'(vblank), 1);

        yrd_cnt = 0;
        run_to(3, 0);
        chk("yrd_blank_lines", 32'(yrd_cnt), 0);

        run_to(3, 286);
        chk("fs_before_xy", 32'(frame_start), 0);
        tick();
        chk("sav_xy_l3", 32'(d_out), 32'h80);
        chk("fs_l3", 32'(frame_start), 1);
        chk("hact_sav", 32'(hactive), 0);
        yrd_cnt = 0;
        tick();
        chk("cb0_l3", 32'(d_out), 32'h80);
        chk("hact_act", 32'(hactive), 1);
        tick();
        chk("y0_l3", 32'(d_out), 32'(last_fed));
        run_to(4, 0);
        chk("yrd_cnt_l3", 32'(yrd_cnt), 720);
        chk("ramp_l3", 32'(ramp_err), 0);
        chk("fs_low_eav", 32'(frame_start), 0);

        run_to(8, 3);
        chk("eav_xy_l8", 32'(d_out), 32'hF1);
        chk("field_l8", 32'(field), 1);
        run_to(8, 287);
        chk("sav_xy_l8", 32'(d_out), 32'hEC);
        chk("fs_l8", 32'(frame_start), 0);

        run_to(10, 287);
        chk("sav_xy_l10", 32'(d_out), 32'hC7);
        chk("fs_l10", 32'(frame_start), 1);
        chk("vblank_l10", 32'(vblank), 0);

        run_to(11, 500);
        chk("uf_before", 32'(underflow), 0);
        drop = 1;
        drop_obs = 8'hAA;
        while (drop && ln == 11) tick();
        chk("uf_byte", 32'(drop_obs), 32'h10);
        chk("uf_set", 32'(underflow), 1);
        run_to(12, 0);
        chk("eav_after_uf", 32'(d_out), 32'hFF);
        chk("uf_sticky", 32'(underflow), 1);

        ovr_q.push_back(8'h00);
        ovr_q.push_back(8'hFF);
        ovr_q.push_back(8'h7F);
        run_to(12, 300);
        chk("clip_n", 32'(ovr_obs.size()), 3);
        if (ovr_obs.size() == 3) begin
`ifdef BT656_CLIP_EN
            chk("clip_00", 32'(ovr_obs[0]), 32'h01);
            chk("clip_ff", 32'(ovr_obs[1]), 32'hFE);
`else
            chk("pass_00", 32'(ovr_obs[0]), 32'h00);
            chk("pass_ff", 32'(ovr_obs[1]), 32'hFF);
`endif
            chk("pass_7f", 32'(ovr_obs[2]), 32'h7F);
        end

        run_to(1, 3);
        chk("wrap_xy", 32'(d_out), 32'hB6);
        chk("wrap_field", 32'(field), 0);

        run_to(5, 900);
        reset = 1'b1;
        tick();
        chk_reset_vals("midline_reset");
        chk("uf_cleared_y_rd", 32'(y_rd), 0);
        ln = 1; hc = -1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("eav_restart", 32'(d_out), 32'(eav1[i]));
        end
        chk("ramp_total", 32'(ramp_err), 0);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
